// File: rtl/pixel_readout.sv
// Captures each released pixel row into a two-entry ping-pong buffer and streams it out pixel by pixel.
// Latency: o_valid rises 2 edges after the row change is sampled; it holds all outputs until i_ready accepts them.
module pixel_readout #(
    parameter int PIXEL_ARRAY_HEIGHT = 2,
    parameter int PIXEL_ARRAY_WIDTH  = 2,
    parameter int PIXEL_BITS         = 8
) (
    input  logic                                                                  clk,
    input  logic                                                                  reset,
    input  logic                                                                  p_erase,
    input  logic [PIXEL_ARRAY_HEIGHT-1:0]                                         p_row_select,
    input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]                               p_data,
    output logic [PIXEL_BITS-1:0]                                                 o_pixel,
    output logic                                                                  o_valid,
    input  logic                                                                  i_ready,
    output logic [((PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1)-1:0] o_row,
    output logic [((PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1)-1:0]   o_col,
    output logic                                                                  o_sof,
    output logic                                                                  o_eol,
    output logic                                                                  o_overrun,
    output logic                                                                  o_sel_error
);
    localparam int RW = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
    localparam int CW = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1;
    localparam int DW = PIXEL_ARRAY_WIDTH * PIXEL_BITS;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                        state_q, state_d;
    logic [PIXEL_ARRAY_HEIGHT-1:0] rs_q;
    logic [DW-1:0]                 data_q;
    logic                          erase_q;
    logic [DW-1:0]                 buf_dat_q [2];
    logic [RW-1:0]                 buf_row_q [2];
    logic [1:0]                    full_q, full_d;
    logic                          wr_ptr_q, wr_ptr_d;
    logic                          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                 col_q, col_d;
    logic                          sof_pend_q, sof_pend_d;
    logic                          show_sof_q, show_sof_d;
    logic                          overrun_q, overrun_d;
    logic                          sel_err_q, sel_err_d;

    logic rs_onehot, ps_multi, ps_onehot, capture, erase_rise, last_col;
    logic load, load_ptr, cap_wr, streaming;
    int   pix_lsb;

    function automatic logic [RW-1:0] onehot_idx(input logic [PIXEL_ARRAY_HEIGHT-1:0] v);
        logic [RW-1:0] idx;
        idx = '0;
        for (int i = 0; i < PIXEL_ARRAY_HEIGHT; i++) begin
            if (v[i]) idx = RW'(i);
        end
        return idx;
    endfunction

    always_comb begin
        rs_onehot  = (rs_q != '0) && ((rs_q & (rs_q - PIXEL_ARRAY_HEIGHT'(1))) == '0);
        ps_multi   = (p_row_select & (p_row_select - PIXEL_ARRAY_HEIGHT'(1))) != '0;
        ps_onehot  = (p_row_select != '0) && !ps_multi;
        capture    = rs_onehot && (p_row_select != rs_q);
        erase_rise = p_erase && !erase_q;
        last_col   = (col_q == CW'(PIXEL_ARRAY_WIDTH - 1));
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        full_d     = full_q;
        sof_pend_d = sof_pend_q;
        show_sof_d = show_sof_q;
        overrun_d  = overrun_q;
        sel_err_d  = sel_err_q;
        load       = 1'b0;
        load_ptr   = rd_ptr_q;
        cap_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                if (full_q[rd_ptr_q]) begin
                    load    = 1'b1;
                    state_d = STREAM;
                    col_d   = '0;
                end
            end
            STREAM: begin
                if (i_ready) begin
                    if (last_col) begin
                        full_d[rd_ptr_q] = 1'b0;
                        rd_ptr_d         = ~rd_ptr_q;
                        load_ptr         = ~rd_ptr_q;
                        col_d            = '0;
                        if (show_sof_q) sof_pend_d = 1'b0;
                        // Back-to-back rows: keep o_valid high when the other buffer is waiting.
                        if (full_q[~rd_ptr_q]) load = 1'b1;
                        else state_d = IDLE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (erase_rise) begin
            sof_pend_d = 1'b1;
            overrun_d  = 1'b0;
            sel_err_d  = 1'b0;
        end

        // The sof tag is frozen at load so it cannot change while a pixel is held.
        if (load) show_sof_d = sof_pend_d && (buf_row_q[load_ptr] == '0);

        if (capture) begin
            if (!full_d[wr_ptr_q]) begin
                cap_wr           = 1'b1;
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = ~wr_ptr_q;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (ps_multi) sel_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rs_q       <= '0;
            data_q     <= '0;
            erase_q    <= 1'b0;
            full_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            col_q      <= '0;
            sof_pend_q <= 1'b1;
            show_sof_q <= 1'b0;
            overrun_q  <= 1'b0;
            sel_err_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_dat_q[i] <= '0;
                buf_row_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rs_q       <= p_row_select;
            erase_q    <= p_erase;
            full_q     <= full_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            col_q      <= col_d;
            sof_pend_q <= sof_pend_d;
            show_sof_q <= show_sof_d;
            overrun_q  <= overrun_d;
            sel_err_q  <= sel_err_d;
            if (ps_onehot) data_q <= p_data;
            if (cap_wr) begin
                buf_dat_q[wr_ptr_q] <= data_q;
                buf_row_q[wr_ptr_q] <= onehot_idx(rs_q);
            end
        end
    end

    always_comb begin
        streaming   = (state_q == STREAM);
        pix_lsb     = int'(col_q) * PIXEL_BITS;
        o_valid     = streaming;
        o_pixel     = streaming ? buf_dat_q[rd_ptr_q][pix_lsb +: PIXEL_BITS] : '0;
        o_row       = streaming ? buf_row_q[rd_ptr_q] : '0;
        o_col       = streaming ? col_q : '0;
        o_sof       = streaming && show_sof_q && (col_q == '0);
        o_eol       = streaming && last_col;
        o_overrun   = overrun_q;
        o_sel_error = sel_err_q;
    end
endmodule

// File: tb/tb_pixel_readout.sv
// Bench for pixel_readout: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a queue-based model of captured rows.
module tb_pixel_readout;
    localparam int H = 2;
    localparam int W = 2;
    localparam int B = 8;

    logic          clk;
    logic          reset;
    logic          p_erase;
    logic [H-1:0]  p_row_select;
    logic [W*B-1:0] p_data;
    logic [B-1:0]  o_pixel;
    logic          o_valid;
    logic          i_ready;
    logic [0:0]    o_row;
    logic [0:0]    o_col;
    logic          o_sof, o_eol, o_overrun, o_sel_error;

    pixel_readout #(.PIXEL_ARRAY_HEIGHT(H), .PIXEL_ARRAY_WIDTH(W), .PIXEL_BITS(B)) dut (
        .clk(clk), .reset(reset), .p_erase(p_erase), .p_row_select(p_row_select),
        .p_data(p_data), .o_pixel(o_pixel), .o_valid(o_valid), .i_ready(i_ready),
        .o_row(o_row), .o_col(o_col), .o_sof(o_sof), .o_eol(o_eol),
        .o_overrun(o_overrun), .o_sel_error(o_sel_error)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    typedef struct { int row; logic [W*B-1:0] dat; bit sof; } ent_t;
    ent_t        m_q[$];
    ent_t        m_cur;
    bit          m_strm = 0;
    int          m_col = 0;
    bit          m_pend = 1, m_ovr = 0, m_serr = 0, m_erase_prev = 0;
    logic [H-1:0] m_prev_sel = '0;
    logic [W*B-1:0] m_last_dat = '0;

    function automatic int popc(input logic [H-1:0] v);
        int n = 0;
        for (int i = 0; i < H; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int sel_idx(input logic [H-1:0] v);
        int r = 0;
        for (int i = 0; i < H; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic m_reset();
        m_q.delete();
        m_strm = 0; m_col = 0; m_pend = 1; m_ovr = 0; m_serr = 0;
        m_erase_prev = 0; m_prev_sel = '0; m_last_dat = '0;
    endtask

    task automatic m_step();
        ent_t e;
        if (m_strm && i_ready) begin
            if (m_col == W - 1) begin
                if (m_cur.sof) m_pend = 0;
                m_strm = 0;
            end else begin
                m_col++;
            end
        end
        if (p_erase && !m_erase_prev) begin
            m_pend = 1; m_ovr = 0; m_serr = 0;
        end
        if (!m_strm && m_q.size() > 0) begin
            e = m_q.pop_front();
            e.sof = m_pend && (e.row == 0);
            m_cur = e; m_col = 0; m_strm = 1;
        end
        if (popc(m_prev_sel) == 1 && p_row_select != m_prev_sel) begin
            if (m_q.size() + int'(m_strm) < 2) begin
                e.row = sel_idx(m_prev_sel); e.dat = m_last_dat; e.sof = 0;
                m_q.push_back(e);
            end else begin
                m_ovr = 1;
            end
        end
        if (popc(p_row_select) > 1) m_serr = 1;
        if (popc(p_row_select) == 1) m_last_dat = p_data;
        m_prev_sel = p_row_select;
        m_erase_prev = p_erase;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) m_reset();
        else m_step();
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        logic [W*B-1:0] d;
        d = m_cur.dat;
        chk("valid", 32'(o_valid), 32'(m_strm));
        chk("pixel", 32'(o_pixel), m_strm ? 32'(d[m_col*B +: B]) : 32'd0);
        chk("row",   32'(o_row),   m_strm ? 32'(m_cur.row) : 32'd0);
        chk("col",   32'(o_col),   m_strm ? 32'(m_col) : 32'd0);
        chk("sof",   32'(o_sof),   32'(m_strm && m_cur.sof && m_col == 0));
        chk("eol",   32'(o_eol),   32'(m_strm && m_col == W - 1));
        chk("overrun", 32'(o_overrun), 32'(m_ovr));
        chk("sel_error", 32'(o_sel_error), 32'(m_serr));
    end

    // Log of accepted pixels, for the directed literal checks.
    typedef struct { int row; int col; int pix; bit sof; bit eol; } acc_t;
    acc_t acc_q[$];
    always @(negedge clk) begin
        acc_t a;
        if (o_valid && i_ready && !reset) begin
            a.row = int'(o_row); a.col = int'(o_col); a.pix = int'(o_pixel);
            a.sof = o_sof; a.eol = o_eol;
            acc_q.push_back(a);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_acc(input string nm, input int i, input int row, input int pix, input bit sof, input bit eol);
        if (acc_q.size() <= i) begin
            chk({nm, "_present"}, 32'(acc_q.size()), 32'(i + 1));
        end else begin
            chk({nm, "_row"}, 32'(acc_q[i].row), 32'(row));
            chk({nm, "_pix"}, 32'(acc_q[i].pix), 32'(pix));
            chk({nm, "_sof"}, 32'(acc_q[i].sof), 32'(sof));
            chk({nm, "_eol"}, 32'(acc_q[i].eol), 32'(eol));
        end
    endtask

    initial begin
        reset = 1'b1; p_erase = 1'b0; p_row_select = '0; p_data = '0; i_ready = 1'b1;
        tick(2);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_pixel", 32'(o_pixel), 0);
        chk("rst_flags", {30'd0, o_overrun, o_sel_error}, 0);
        reset = 1'b0;
        tick(1);

        // Basic two-row frame
        acc_q.delete();
        p_erase = 1; tick(1); p_erase = 0;
        p_row_select = 2'b01; p_data = 16'hBBAA; tick(4);
        p_row_select = 2'b10; p_data = 16'hDDCC; tick(1);
        chk("lat_edge1_valid", 32'(o_valid), 0);
        tick(1);
        chk("lat_edge2_valid", 32'(o_valid), 1);
        chk("lat_edge2_pixel", 32'(o_pixel), 32'hAA);
        chk("lat_edge2_sof", 32'(o_sof), 1);
        tick(2);
        p_row_select = 2'b00; tick(6);
        chk("frame_count", 32'(acc_q.size()), 4);
        chk_acc("f0", 0, 0, 32'hAA, 1, 0);
        chk_acc("f1", 1, 0, 32'hBB, 0, 1);
        chk_acc("f2", 2, 1, 32'hCC, 0, 0);
        chk_acc("f3", 3, 1, 32'hDD, 0, 1);

        // Backpressure hold
        acc_q.delete();
        i_ready = 0;
        p_erase = 1; tick(1); p_erase = 0;
        p_row_select = 2'b01; p_data = 16'hBBAA; tick(4);
        p_row_select = 2'b10; p_data = 16'hDDCC; tick(2);
        for (int i = 0; i < 5; i++) begin
            chk("hold_pixel", 32'(o_pixel), 32'hAA);
            chk("hold_rowcol", {30'd0, o_row, o_col}, 0);
            chk("hold_sof", 32'(o_sof), 1);
            if (i == 1) p_row_select = 2'b00;
            tick(1);
        end
        i_ready = 1; tick(1);
        chk("bp_first_accept", 32'(acc_q.size()), 1);
        chk_acc("bp0", 0, 0, 32'hAA, 1, 0);
        tick(6);
        chk("bp_count", 32'(acc_q.size()), 4);

        // Overrun
        acc_q.delete();
        i_ready = 0;
        p_row_select = 2'b01; p_data = 16'h1111; tick(2);
        p_row_select = 2'b10; p_data = 16'h2222; tick(2);
        p_row_select = 2'b01; p_data = 16'h3333; tick(2);
        p_row_select = 2'b00; tick(3);
        chk("ovr_set", 32'(o_overrun), 1);
        i_ready = 1; tick(8);
        chk("ovr_count", 32'(acc_q.size()), 4);
        chk_acc("ovr0", 0, 0, 32'h11, 0, 0);
        chk_acc("ovr2", 2, 1, 32'h22, 0, 0);
        p_erase = 1; tick(1); p_erase = 0;
        chk("ovr_cleared", 32'(o_overrun), 0);

        // Multi-hot select
        acc_q.delete();
        p_row_select = 2'b11; p_data = 16'h9999; tick(3);
        chk("mh_sel_error", 32'(o_sel_error), 1);
        p_row_select = 2'b00; tick(4);
        chk("mh_no_capture", 32'(acc_q.size()), 0);
        p_erase = 1; tick(1); p_erase = 0;
        chk("mh_cleared", 32'(o_sel_error), 0);

        // Capture coinciding with last-column accept while both buffers full
        i_ready = 0;
        p_row_select = 2'b01; p_data = 16'h4140; tick(2);
        p_row_select = 2'b10; p_data = 16'h5150; tick(2);
        p_row_select = 2'b01; p_data = 16'h6160; tick(3);
        acc_q.delete();
        i_ready = 1; tick(1);
        p_row_select = 2'b00; tick(1);
        chk("sim_no_overrun", 32'(o_overrun), 0);
        tick(8);
        chk("sim_count", 32'(acc_q.size()), 6);
        chk_acc("sim0", 0, 0, 32'h40, 1, 0);
        chk_acc("sim3", 3, 1, 32'h51, 0, 1);
        chk_acc("sim4", 4, 0, 32'h60, 0, 0);
        chk_acc("sim5", 5, 0, 32'h61, 0, 1);

        // Reset mid-row
        i_ready = 0;
        p_row_select = 2'b01; p_data = 16'h7170; tick(2);
        p_row_select = 2'b00; tick(2);
        i_ready = 1; tick(1);
        i_ready = 0; tick(1);
        chk("mid_col", 32'(o_col), 1);
        chk("mid_valid", 32'(o_valid), 1);
        #2 reset = 1;
        #1;
        chk("async_valid", 32'(o_valid), 0);
        chk("async_pixel", 32'(o_pixel), 0);
        chk("async_col", 32'(o_col), 0);
        acc_q.delete();
        tick(2);
        reset = 0; i_ready = 1;
        tick(5);
        chk("post_rst_nothing", 32'(acc_q.size()), 0);
        chk("post_rst_valid", 32'(o_valid), 0);

        // Randomized run against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 2) == 0) p_row_select = 2'($urandom_range(0, 3));
            p_data  = 16'($urandom);
            i_ready = ($urandom_range(0, 9) < 7);
            p_erase = ($urandom_range(0, 29) == 0);
            tick(1);
        end
        p_row_select = '0; p_erase = 0; i_ready = 1;
        tick(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
